// File: rtl/button_stim_pkg.sv
// button_stim_pkg: shared FSM state and event-table entry types for the button stimulus sequencer.
// Entry fields are sized for the widest supported configuration; instances use the low bits.
package button_stim_pkg;
    localparam int MAX_STEP_W  = 64;
    localparam int MAX_BUTTONS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_STEP_W-1:0]  step;
        logic [MAX_BUTTONS-1:0] press;
        logic [MAX_BUTTONS-1:0] release_mask;
        logic                   last;
    } evt_t;

    localparam evt_t EVT_RESET = '{step: '1, press: '0, release_mask: '0, last: 1'b1};
endpackage

// File: rtl/key_matrix_encode.sv
// key_matrix_encode: drives the CPU K lines from pressed buttons whose mapped strobe is active.
module key_matrix_encode #(
    parameter int NUM_BUTTONS = 8,
    parameter int STROBE_W    = 8,
    parameter int K_W         = 4
) (
    input  logic [NUM_BUTTONS-1:0]     pressed,
    input  logic [STROBE_W-1:0]        shifter_s,
    input  logic [$clog2(STROBE_W)-1:0] map_strobe [NUM_BUTTONS],
    input  logic [$clog2(K_W)-1:0]      map_kbit   [NUM_BUTTONS],
    output logic [K_W-1:0]             input_k
);
    localparam int KB = $clog2(K_W);

    always_comb begin
        input_k = '0;
        for (int b = 0; b < NUM_BUTTONS; b++)
            for (int k = 0; k < K_W; k++)
                input_k[k] = input_k[k] | (pressed[b] & shifter_s[map_strobe[b]] & (map_kbit[b] == KB'(k)));
    end
endmodule

// File: rtl/button_stim_seq.sv
// button_stim_seq: replays a table of step-stamped button press/release events into a
// strobe/K key matrix, pacing playback by retired CPU instructions.
module button_stim_seq
    import button_stim_pkg::*;
#(
    parameter int NUM_BUTTONS = 8,
    parameter int NUM_EVENTS  = 16,
    parameter int STROBE_W    = 8,
    parameter int K_W         = 4,
    parameter int STEP_W      = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            step_pulse,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            evt_we,
    input  logic [$clog2(NUM_EVENTS)-1:0]   evt_addr,
    input  logic [STEP_W-1:0]               evt_step,
    input  logic [NUM_BUTTONS-1:0]          evt_press,
    input  logic [NUM_BUTTONS-1:0]          evt_release,
    input  logic                            evt_last,
    input  logic                            map_we,
    input  logic [$clog2(NUM_BUTTONS)-1:0]  map_addr,
    input  logic [$clog2(STROBE_W)-1:0]     map_strobe,
    input  logic [$clog2(K_W)-1:0]          map_kbit,
    input  logic [STROBE_W-1:0]             shifter_s,
    output logic [K_W-1:0]                  input_k,
    output logic [NUM_BUTTONS-1:0]          pressed,
    output logic [STEP_W-1:0]               step_count,
    output logic [1:0]                      state,
    output logic                            done
);
    localparam int EW = $clog2(NUM_EVENTS);
    localparam int SW = $clog2(STROBE_W);
    localparam int KW = $clog2(K_W);

    state_t                 state_q, state_d;
    logic [EW-1:0]          ptr;
    logic [STEP_W-1:0]      step_cnt;
    logic [NUM_BUTTONS-1:0] pressed_q;
    evt_t                   tab [NUM_EVENTS];
    logic [SW-1:0]          m_strobe [NUM_BUTTONS];
    logic [KW-1:0]          m_kbit   [NUM_BUTTONS];
    evt_t                   cur;
    logic                   hit, is_last, unused_evt;

    assign cur        = tab[ptr];
    assign unused_evt = ^cur;
    // abort outranks event application in the same cycle
    assign hit     = state_q == RUN && !abort && step_cnt >= cur.step[STEP_W-1:0];
    assign is_last = cur.last || ptr == EW'(NUM_EVENTS - 1);

    always_comb begin
        state_d = (abort && state_q != IDLE) ? IDLE :
                  (state_q == IDLE && start) ? RUN  :
                  (hit && is_last)           ? DONE : state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr       <= '0;
            step_cnt  <= '0;
            pressed_q <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) tab[i] <= EVT_RESET;
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                m_strobe[b] <= '0;
                m_kbit[b]   <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (evt_we)
                    tab[evt_addr] <= '{step: MAX_STEP_W'(evt_step), press: MAX_BUTTONS'(evt_press),
                                       release_mask: MAX_BUTTONS'(evt_release), last: evt_last};
                if (map_we) begin
                    m_strobe[map_addr] <= map_strobe;
                    m_kbit[map_addr]   <= map_kbit;
                end
                if (start) begin
                    step_cnt  <= '0;
                    ptr       <= '0;
                    pressed_q <= '0;
                end
            end else if (abort) begin
                ptr       <= '0;
                pressed_q <= '0;
            end else begin
                if (step_pulse && step_cnt != '1) step_cnt <= step_cnt + 1'b1;
                if (hit) begin
                    pressed_q <= (pressed_q & ~cur.release_mask[NUM_BUTTONS-1:0]) | cur.press[NUM_BUTTONS-1:0];
                    ptr       <= ptr + 1'b1;
                end
            end
        end
    end

    assign pressed    = pressed_q;
    assign step_count = step_cnt;
    assign state      = state_q;
    assign done       = state_q == DONE;

    key_matrix_encode #(
        .NUM_BUTTONS(NUM_BUTTONS),
        .STROBE_W   (STROBE_W),
        .K_W        (K_W)
    ) u_enc (
        .pressed   (pressed_q),
        .shifter_s (shifter_s),
        .map_strobe(m_strobe),
        .map_kbit  (m_kbit),
        .input_k   (input_k)
    );
endmodule

// File: tb/tb_button_stim_seq.sv
// tb_button_stim_seq: checks the sequencer against an event-queue reference model, constant
// vectors and directed corner cases; a second instance with 8-bit steps covers saturation.
module tb_button_stim_seq;
    localparam int NB = 8, NE = 16;

    logic clk = 0, reset = 0, step_pulse = 0, start = 0, abort = 0;
    logic evt_we = 0, evt_last = 0, map_we = 0;
    logic [3:0] evt_addr = 0;
    logic [31:0] evt_step = 0;
    logic [7:0] evt_press = 0, evt_release = 0, shifter_s = 0;
    logic [2:0] map_addr = 0, map_strobe = 0;
    logic [1:0] map_kbit = 0;
    logic [3:0] input_k, input_k8;
    logic [7:0] pressed, pressed8, step_count8;
    logic [31:0] step_count;
    logic [1:0] state, state8;
    logic done, done8;

    int n_checks = 0, n_pass = 0;

    button_stim_seq dut (
        .clk(clk), .reset(reset), .step_pulse(step_pulse), .start(start), .abort(abort),
        .evt_we(evt_we), .evt_addr(evt_addr), .evt_step(evt_step), .evt_press(evt_press),
        .evt_release(evt_release), .evt_last(evt_last), .map_we(map_we), .map_addr(map_addr),
        .map_strobe(map_strobe), .map_kbit(map_kbit), .shifter_s(shifter_s), .input_k(input_k),
        .pressed(pressed), .step_count(step_count), .state(state), .done(done)
    );

    button_stim_seq #(.STEP_W(8)) dut8 (
        .clk(clk), .reset(reset), .step_pulse(step_pulse), .start(start), .abort(abort),
        .evt_we(evt_we), .evt_addr(evt_addr), .evt_step(evt_step[7:0]), .evt_press(evt_press),
        .evt_release(evt_release), .evt_last(evt_last), .map_we(map_we), .map_addr(map_addr),
        .map_strobe(map_strobe), .map_kbit(map_kbit), .shifter_s(shifter_s), .input_k(input_k8),
        .pressed(pressed8), .step_count(step_count8), .state(state8), .done(done8)
    );

    always #5 clk = ~clk;

    // Reference: the table as written in IDLE; playback is a queue of pending events
    // popped one per clock once the step count reaches the head's step.
    typedef struct { logic [31:0] step; logic [7:0] press, rel; logic last; } ev_t;
    ev_t tab [NE];
    ev_t q [$];
    int ms [NB], mk [NB];
    int m_st;
    logic [31:0] m_cnt;
    logic [7:0] m_pr;

    function automatic void model_reset();
        m_st = 0; m_cnt = 0; m_pr = 0; q.delete();
        for (int i = 0; i < NE; i++) tab[i] = '{32'hFFFF_FFFF, 8'h00, 8'h00, 1'b1};
        for (int b = 0; b < NB; b++) begin ms[b] = 0; mk[b] = 0; end
    endfunction

    function automatic void model_edge();
        if (m_st != 0 && abort) begin
            m_st = 0; m_pr = 0; q.delete();
        end else if (m_st == 0) begin
            if (evt_we) tab[evt_addr] = '{evt_step, evt_press, evt_release, evt_last};
            if (map_we) begin ms[map_addr] = int'(map_strobe); mk[map_addr] = int'(map_kbit); end
            if (start) begin
                m_st = 1; m_cnt = 0; m_pr = 0; q.delete();
                for (int i = 0; i < NE; i++) begin
                    q.push_back(tab[i]);
                    if (tab[i].last) break;
                end
            end
        end else begin
            if (m_st == 1 && m_cnt >= q[0].step) begin
                m_pr = (m_pr & ~q[0].rel) | q[0].press;
                void'(q.pop_front());
                if (q.size() == 0) m_st = 2;
            end
            if (step_pulse && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic logic [3:0] model_k();
        logic [3:0] k = 0;
        for (int b = 0; b < NB; b++)
            if (m_pr[b] && shifter_s[ms[b]]) k[mk[b]] = 1'b1;
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_model();
        logic [1:0] st = m_st[1:0];
        check("model", {17'd0, state, done, pressed, step_count, input_k},
                       {17'd0, st, m_st == 2, m_pr, m_cnt, model_k()});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        start = 0; abort = 0; evt_we = 0; map_we = 0;
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic wr_evt(input int a, input logic [31:0] s, input logic [7:0] p, input logic [7:0] r, input logic l);
        evt_we = 1; evt_addr = 4'(a); evt_step = s; evt_press = p; evt_release = r; evt_last = l;
        tick();
    endtask

    task automatic wr_map(input int b, input int s, input int k);
        map_we = 1; map_addr = 3'(b); map_strobe = 3'(s); map_kbit = 2'(k);
        tick();
    endtask

    task automatic run_to(input logic [31:0] target);
        for (int i = 0; i < 50000 && m_cnt < target; i++) begin
            step_pulse = 1;
            shifter_s = 8'($urandom);
            tick();
        end
        step_pulse = 0;
        check("reach_step", 64'(step_count), 64'(target));
    endtask

    typedef struct { logic [7:0] s; logic [3:0] k; } vec_t;
    vec_t vecs [7];

    initial begin
        vecs = '{'{8'h06, 4'h6}, '{8'h02, 4'h4}, '{8'h04, 4'h2}, '{8'h00, 4'h0},
                 '{8'h01, 4'h0}, '{8'hF9, 4'h0}, '{8'hFF, 4'h6}};
        model_reset();
        shifter_s = 8'hFF;
        do_reset();
        check("rst_state", 64'(state), 0);
        check("rst_pressed", 64'(pressed), 0);
        check("rst_step", 64'(step_count), 0);
        check("rst_done", 64'(done), 0);
        check("rst_k", 64'(input_k), 0);
        check("rst8_all", {45'd0, state8, done8, pressed8, input_k8}, 0);

        // long-step press window on strobe 1 / K bit 2
        wr_map(0, 1, 2);
        wr_evt(0, 32'h8000, 8'h01, 8'h00, 0);
        wr_evt(1, 32'h8400, 8'h00, 8'h01, 1);
        start = 1; tick();
        check("run_entered", 64'(state), 1);
        run_to(32'h7FF0);
        shifter_s = 8'h02; #1;
        check("k_before_window", 64'(input_k), 0);
        run_to(32'h8200);
        shifter_s = 8'h02; #1;
        check("k_in_window", 64'(input_k), 4'h4);
        shifter_s = 8'hFD; #1;
        check("k_other_strobe", 64'(input_k), 0);
        run_to(32'h8400);
        tick();
        check("done_at_8400", {31'd0, done, step_count}, {31'd1, 32'h8400});
        shifter_s = 8'h02; #1;
        check("k_after_release", 64'(input_k), 0);

        // two buttons on separate strobes/K bits
        abort = 1; tick();
        check("abort_from_done", {60'd0, state, pressed[1:0]}, 0);
        wr_map(1, 2, 1);
        wr_evt(0, 5, 8'h03, 8'h00, 1);
        start = 1; tick();
        run_to(5);
        tick();
        check("press_03", {55'd0, done, pressed}, {55'd1, 8'h03});
        for (int i = 0; i < 7; i++) begin
            shifter_s = vecs[i].s; #1;
            check("k_vector", 64'(input_k), 64'(vecs[i].k));
        end

        // equal-step events apply on consecutive clocks
        abort = 1; tick();
        wr_evt(0, 10, 8'h01, 8'h00, 0);
        wr_evt(1, 10, 8'h02, 8'h00, 0);
        wr_evt(2, 10, 8'h04, 8'h00, 1);
        start = 1; tick();
        run_to(10);
        check("eq_step_none", 64'(pressed), 0);
        tick(); check("eq_step_1", 64'(pressed), 8'h01);
        tick(); check("eq_step_2", 64'(pressed), 8'h03);
        tick(); check("eq_step_3", {55'd0, done, pressed}, {55'd1, 8'h07});

        // abort beats start; table writes outside IDLE are dropped
        abort = 1; tick();
        wr_evt(0, 2, 8'h05, 8'h00, 0);
        wr_evt(1, 200, 8'h80, 8'h00, 1);
        start = 1; tick();
        run_to(4);
        check("pressed_05", 64'(pressed), 8'h05);
        abort = 1; start = 1; tick();
        check("abort_start", {54'd0, state, pressed}, 0);
        start = 1; tick();
        wr_evt(0, 0, 8'hFF, 8'h00, 1);
        wr_map(0, 3, 3);
        abort = 1; tick();
        start = 1; tick();
        run_to(4);
        check("rerun_table", {54'd0, state, pressed}, {54'd1, 8'h05});

        // randomized playback, with stray writes, aborts and starts mixed in
        abort = 1; tick();
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NE; i++)
                wr_evt(i, $urandom_range(0, 60), 8'($urandom), 8'($urandom), $urandom_range(0, 5) == 0);
            for (int b = 0; b < NB; b++) wr_map(b, $urandom_range(0, 7), $urandom_range(0, 3));
            start = 1; tick();
            for (int c = 0; c < 120; c++) begin
                step_pulse = 1'($urandom_range(0, 1));
                shifter_s = 8'($urandom);
                evt_we = $urandom_range(0, 19) == 0;
                evt_addr = 4'($urandom); evt_step = $urandom_range(0, 60);
                evt_press = 8'($urandom); evt_release = 8'($urandom); evt_last = 1'($urandom);
                map_we = $urandom_range(0, 19) == 0;
                map_addr = 3'($urandom); map_strobe = 3'($urandom); map_kbit = 2'($urandom);
                abort = $urandom_range(0, 99) == 0;
                start = $urandom_range(0, 29) == 0;
                tick();
            end
            step_pulse = 0;
            abort = 1; tick();
        end

        // reset mid-run on the 8-bit-step instance, then saturation over a restored table
        shifter_s = 8'hFF;
        do_reset();
        wr_evt(0, 50, 8'h0F, 8'h00, 0);
        wr_evt(1, 250, 8'hF0, 8'h00, 1);
        start = 1; tick();
        run_to(100);
        check("run8_at_100", {46'd0, state8, pressed8, step_count8}, {46'd1, 8'h0F, 8'd100});
        shifter_s = 8'hFF;
        do_reset();
        check("rst8_mid_run", {41'd0, state8, done8, pressed8, step_count8, input_k8}, 0);
        start = 1; tick();
        for (int i = 0; i < 300; i++) begin
            step_pulse = 1;
            tick();
        end
        step_pulse = 0;
        tick();
        check("sat8_step", 64'(step_count8), 8'hFF);
        check("sat8_done", {55'd0, done8, pressed8}, {55'd1, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
